load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Multi-cycle load/store sequencer between the control unit/ALU and the data memory bus of the RISC-V core.
- Takes the ALU address and rs2 data, plus the control unit's MemRW, WSel and RSel codes.
- Issues one byte-lane-enabled bus transaction with a req/ack handshake.
- Returns sign/zero-extended load data for writeback and stalls the PC until the access completes.

Parameters:
- TIMEOUT_CYCLES, 255, bus-wait cycles before abort; used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  current instruction is a load or store
- MemRW  in  1  1 = store, 0 = load
- WSel  in  2  store width: 00 byte, 01 half, 10 word, 11 illegal
- RSel  in  3  load type: 000 LB, 010 LH, 011 LW, 100 LBU, 101 LHU, others illegal
- addr  in  32  byte address from ALU
- wdata  in  32  store data (rs2)
- rdata  out  32  extended load result
- done  out  1  one-cycle completion pulse
- stall  out  1  hold PC/instruction
- misaligned  out  1  one-cycle fault flag, coincident with done
- bus_req  out  1  bus request
- bus_we  out  1  bus write enable
- bus_addr  out  32  word address, {addr[31:2],2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated write data
- bus_rdata  in  32  bus read word
- bus_ack  in  1  bus completion

Behaviour:
- Reset values: all outputs 0, state IDLE. Reset is asynchronous.
- Reset mid-transaction: bus_req drops immediately and the access is abandoned; no done pulse.

State machine (IDLE, BUS, DONE, ERR):
- IDLE, req_valid=1, legal and aligned: latch addr, wdata, MemRW, WSel, RSel; go to BUS.
- IDLE, req_valid=1, misaligned or illegal code: go to ERR. No bus activity.
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=00.
- BUS: bus_req=1 and bus_we/bus_addr/bus_be/bus_wdata held stable from the latched values. On bus_ack=1 go to DONE; for loads, capture the extended rdata on the same edge.
- DONE: done=1 for one cycle, then IDLE.
- ERR: done=1 and misaligned=1 for one cycle, rdata unchanged, then IDLE.

stall:
- stall = req_valid & (state != DONE) & (state != ERR). Combinational.
- A request is released in the DONE/ERR cycle, so the PC advances on that edge.
- Minimum latency is 3 cycles (IDLE, BUS with zero-wait ack, DONE).

Request and bus rules:
- Deasserting req_valid while in BUS does not abort; the transaction completes.
- bus_ack outside BUS is ignored.
- A new request is sampled only in IDLE.

Byte enables and write data:
- Byte: bus_be = 4'b0001 << addr[1:0]; bus_wdata = wdata[7:0] replicated 4x.
- Half: bus_be = 4'b0011 << addr[1:0]; bus_wdata = wdata[15:0] replicated 2x.
- Word: bus_be = 4'b1111; bus_wdata = wdata.
- Loads: bus_we=0, bus_be set per width.

Load extraction:
- Select byte/half lane by addr[1:0].
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- rdata holds its value until the next load completes; stores and errors leave it unchanged.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Enabled: a counter clears on entry to BUS and increments each BUS cycle without ack.
  - Reaching TIMEOUT_CYCLES drops bus_req and goes to ERR: done=1, misaligned=1, rdata unchanged.
  - Ack and timeout in the same cycle: ack wins.
- Disabled: no counter; BUS waits indefinitely.

Test Plan:
- LW, addr=0x100, bus_rdata=0xDEADBEEF, ack on first BUS cycle -> bus_be=1111, bus_addr=0x100, rdata=0xDEADBEEF, done in cycle 3, stall high for cycles 1-2.
- LB addr=0x103 and LBU addr=0x103, bus_rdata=0x80FF0000 -> LB rdata=0xFFFFFF80, LBU rdata=0x00000080.
- SH addr=0x202, wdata=0x1234ABCD -> bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD, bus_addr=0x200.
- SW addr=0x101 -> no bus_req, ERR: done=1, misaligned=1 on cycle 2, rdata unchanged.
- LH with ack delayed 5 cycles; rst pulsed on 3rd BUS cycle -> bus_req low immediately, all outputs 0, no done. Re-issue after reset completes normally.
- With LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack never asserted -> bus_req drops after 4 BUS cycles, then done=1 and misaligned=1.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Core-side request/response and data-memory bus signals of the load/store unit.
// master: the LSU's view; slave: the environment (control unit, ALU, memory).
interface load_store_unit_if;
    logic        req_valid;
    logic        MemRW;
    logic [1:0]  WSel;
    logic [2:0]  RSel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        stall;
    logic        misaligned;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        input  req_valid, MemRW, WSel, RSel, addr, wdata, bus_rdata, bus_ack,
        output rdata, done, stall, misaligned, bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );

    modport slave (
        output req_valid, MemRW, WSel, RSel, addr, wdata, bus_rdata, bus_ack,
        input  rdata, done, stall, misaligned, bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store sequencer: one byte-lane bus access per request, PC stall until done.
// Define LSU_TIMEOUT_EN to abort a bus access after TIMEOUT_CYCLES cycles without ack.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic               clk,
    input logic               rst,
    load_store_unit_if.master lsu
);
    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE, S_ERR} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  w_size;
    logic        w_bad;
    logic        w_timeout;
    logic [31:0] r_addr;
    logic [1:0]  r_off;
    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [2:0]  r_rsel;
    logic [31:0] r_rdata;

    // Access size code: 0 byte, 1 half, 2 word, 3 illegal
    function automatic logic [1:0] load_size(input logic [2:0] rsel);
        case (rsel)
            3'b000, 3'b100: load_size = 2'd0;
            3'b010, 3'b101: load_size = 2'd1;
            3'b011:         load_size = 2'd2;
            default:        load_size = 2'd3;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    lane_be = 4'b0001 << off;
            2'd1:    lane_be = 4'b0011 << off;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'd0:    lane_wdata = {4{wd[7:0]}};
            2'd1:    lane_wdata = {2{wd[15:0]}};
            default: lane_wdata = wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] rsel, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [31:0]        lane;
        logic signed [7:0]  s8;
        logic signed [15:0] s16;
        lane = word >> {off, 3'b000};
        s8   = signed'(lane[7:0]);
        s16  = signed'(lane[15:0]);
        case (rsel)
            3'b000:  load_extend = unsigned'(32'(s8));
            3'b010:  load_extend = unsigned'(32'(s16));
            3'b100:  load_extend = {24'd0, lane[7:0]};
            3'b101:  load_extend = {16'd0, lane[15:0]};
            default: load_extend = lane;
        endcase
    endfunction

    assign w_size = lsu.MemRW ? lsu.WSel : load_size(lsu.RSel);
    assign w_bad  = (w_size == 2'd3)
                  || ((w_size == 2'd1) && lsu.addr[0])
                  || ((w_size == 2'd2) && (lsu.addr[1:0] != 2'b00));

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;

    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Held at zero outside BUS so every bus access starts counting from zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state != S_BUS) begin
            r_cnt <= '0;
        end else if (!lsu.bus_ack) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (lsu.req_valid) begin
                    w_next = w_bad ? S_ERR : S_BUS;
                end
            end
            S_BUS: begin
                if (lsu.bus_ack) begin
                    w_next = S_DONE;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Request capture: bus-side values are precomputed here so BUS drives pure registers
    always_ff @(posedge clk) begin
        if ((r_state == S_IDLE) && lsu.req_valid) begin
            r_addr  <= {lsu.addr[31:2], 2'b00};
            r_off   <= lsu.addr[1:0];
            r_we    <= lsu.MemRW;
            r_be    <= lane_be(w_size, lsu.addr[1:0]);
            r_wdata <= lane_wdata(w_size, lsu.wdata);
            r_rsel  <= lsu.RSel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if ((r_state == S_BUS) && lsu.bus_ack && !r_we) begin
            r_rdata <= load_extend(r_rsel, r_off, lsu.bus_rdata);
        end
    end

    assign lsu.bus_req    = (r_state == S_BUS);
    assign lsu.bus_we     = (r_state == S_BUS) && r_we;
    assign lsu.bus_addr   = (r_state == S_BUS) ? r_addr : 32'd0;
    assign lsu.bus_be     = (r_state == S_BUS) ? r_be : 4'd0;
    assign lsu.bus_wdata  = (r_state == S_BUS) ? r_wdata : 32'd0;
    assign lsu.rdata      = r_rdata;
    assign lsu.done       = (r_state == S_DONE) || (r_state == S_ERR);
    assign lsu.misaligned = (r_state == S_ERR);
    assign lsu.stall      = lsu.req_valid && (r_state != S_DONE) && (r_state != S_ERR);
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, random traffic against a reference model,
// and hand sequences for reset abort, ignored ack, request drop and (with LSU_TIMEOUT_EN) timeout.
module tb_load_store_unit;
`ifdef LSU_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;
    logic [31:0] exp_rdata;

    load_store_unit_if lsu_bus ();

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .lsu (lsu_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  wsel;
        logic [2:0]  rsel;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        int          dly;
        logic        err;
        logic [3:0]  be;
        logic [31:0] baddr;
        logic [31:0] bwd;
        logic [31:0] rdata;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request from IDLE to completion; dly<0 means the bus never acks.
    task automatic run_txn(input logic we, input logic [1:0] wsel, input logic [2:0] rsel,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                           input int dly, output int lat, output logic mis, output logic [3:0] be,
                           output logic [31:0] baddr, output logic [31:0] bwd, output logic bwe,
                           output logic saw_req, output logic stall_ok);
        int nbus;
        lsu_bus.req_valid = 1'b1;
        lsu_bus.MemRW     = we;
        lsu_bus.WSel      = wsel;
        lsu_bus.RSel      = rsel;
        lsu_bus.addr      = a;
        lsu_bus.wdata     = wd;
        lsu_bus.bus_rdata = rd;
        lsu_bus.bus_ack   = 1'b0;
        lat = 0; mis = 1'b0; be = '0; baddr = '0; bwd = '0; bwe = 1'b0;
        saw_req = 1'b0; stall_ok = 1'b1; nbus = 0;
        for (int c = 1; c <= 64; c++) begin
            #1;
            if (lsu_bus.done) begin
                lat = c;
                mis = lsu_bus.misaligned;
                if (lsu_bus.stall) stall_ok = 1'b0;
                break;
            end
            if (!lsu_bus.stall) stall_ok = 1'b0;
            if (lsu_bus.bus_req) begin
                if (!saw_req) begin
                    be = lsu_bus.bus_be; baddr = lsu_bus.bus_addr;
                    bwd = lsu_bus.bus_wdata; bwe = lsu_bus.bus_we;
                end
                saw_req = 1'b1;
                lsu_bus.bus_ack = (dly >= 0) && (nbus == dly);
                nbus++;
            end else begin
                lsu_bus.bus_ack = 1'b0;
            end
            tick();
        end
        lsu_bus.req_valid = 1'b0;
        lsu_bus.bus_ack   = 1'b0;
        tick();
    endtask

    // Reference model: derives the access from byte counts and plain arithmetic.
    task automatic model(input logic we, input logic [1:0] wsel, input logic [2:0] rsel,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         output logic err, output logic [3:0] be, output logic [31:0] bwd,
                         output logic [31:0] ld);
        int     n;
        bit     sgn;
        int     off;
        int     bemask;
        longint v;
        longint span;
        n = 0; sgn = 0;
        if (we) begin
            n = (wsel == 0) ? 1 : (wsel == 1) ? 2 : (wsel == 2) ? 4 : 0;
        end else begin
            case (rsel)
                3'd0: begin n = 1; sgn = 1; end
                3'd2: begin n = 2; sgn = 1; end
                3'd3: n = 4;
                3'd4: n = 1;
                3'd5: n = 2;
                default: n = 0;
            endcase
        end
        off    = int'(a % 4);
        err    = (n == 0) || ((a % n) != 0);
        bemask = ((1 << n) - 1) << off;
        be     = bemask[3:0];
        bwd    = '0;
        ld     = '0;
        if (n != 0) begin
            for (int i = 0; i < 4; i++) bwd[8*i +: 8] = wd[8*(i % n) +: 8];
            span = longint'(1) << (8 * n);
            v    = (longint'(rd) >> (8 * off)) % span;
            if (sgn && (v >= span / 2)) v = v - span;
            ld   = v[31:0];
        end
    endtask

    vec_t        tbl[12];
    int          lat;
    logic        mis, bwe, saw, sok;
    logic [3:0]  be;
    logic [31:0] baddr, bwd;
    logic        m_err;
    logic [3:0]  m_be;
    logic [31:0] m_bwd, m_ld;

    initial begin
        n_chk = 0; n_pass = 0;
        tbl[0]  = '{1'b0, 2'd0, 3'b011, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0, 4'hF, 32'h100, 32'h0, 32'hDEADBEEF};
        tbl[1]  = '{1'b0, 2'd0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 0, 1'b0, 4'h8, 32'h100, 32'h0, 32'hFFFFFF80};
        tbl[2]  = '{1'b0, 2'd0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 1, 1'b0, 4'h8, 32'h100, 32'h0, 32'h00000080};
        tbl[3]  = '{1'b1, 2'd1, 3'b000, 32'h202, 32'h1234ABCD, 32'h0, 0, 1'b0, 4'hC, 32'h200, 32'hABCDABCD, 32'h00000080};
        tbl[4]  = '{1'b1, 2'd2, 3'b000, 32'h101, 32'h55555555, 32'h0, 0, 1'b1, 4'h0, 32'h0, 32'h0, 32'h00000080};
        tbl[5]  = '{1'b0, 2'd0, 3'b010, 32'h102, 32'h0, 32'hCAFE1234, 2, 1'b0, 4'hC, 32'h100, 32'h0, 32'hFFFFCAFE};
        tbl[6]  = '{1'b0, 2'd0, 3'b101, 32'h206, 32'h0, 32'h80001234, 0, 1'b0, 4'hC, 32'h204, 32'h0, 32'h00008000};
        tbl[7]  = '{1'b1, 2'd0, 3'b000, 32'h301, 32'h000000A5, 32'h0, 1, 1'b0, 4'h2, 32'h300, 32'hA5A5A5A5, 32'h00008000};
        tbl[8]  = '{1'b0, 2'd0, 3'b001, 32'h000, 32'h0, 32'hFFFFFFFF, 0, 1'b1, 4'h0, 32'h0, 32'h0, 32'h00008000};
        tbl[9]  = '{1'b1, 2'd3, 3'b000, 32'h400, 32'h0, 32'h0, 0, 1'b1, 4'h0, 32'h0, 32'h0, 32'h00008000};
        tbl[10] = '{1'b0, 2'd0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 1'b1, 4'h0, 32'h0, 32'h0, 32'h00008000};
        tbl[11] = '{1'b1, 2'd2, 3'b000, 32'h400, 32'h11223344, 32'h0, 3, 1'b0, 4'hF, 32'h400, 32'h11223344, 32'h00008000};

        lsu_bus.req_valid = 1'b0; lsu_bus.MemRW = 1'b0; lsu_bus.WSel = '0; lsu_bus.RSel = '0;
        lsu_bus.addr = '0; lsu_bus.wdata = '0; lsu_bus.bus_rdata = '0; lsu_bus.bus_ack = 1'b0;
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("reset_outputs", {lsu_bus.done, lsu_bus.stall, lsu_bus.misaligned, lsu_bus.bus_req,
                              lsu_bus.bus_we, lsu_bus.bus_be}, 32'd0);
        chk("reset_rdata", lsu_bus.rdata, 32'd0);
        chk("reset_bus_addr", lsu_bus.bus_addr | lsu_bus.bus_wdata, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) begin
            run_txn(tbl[i].we, tbl[i].wsel, tbl[i].rsel, tbl[i].a, tbl[i].wd, tbl[i].rd, tbl[i].dly,
                    lat, mis, be, baddr, bwd, bwe, saw, sok);
            chk($sformatf("v%0d_latency", i), lat, tbl[i].err ? 32'd2 : 32'(3 + tbl[i].dly));
            chk($sformatf("v%0d_misaligned", i), {31'd0, mis}, {31'd0, tbl[i].err});
            chk($sformatf("v%0d_rdata", i), lsu_bus.rdata, tbl[i].rdata);
            chk($sformatf("v%0d_stall", i), {31'd0, sok}, 32'd1);
            if (tbl[i].err) begin
                chk($sformatf("v%0d_no_bus", i), {31'd0, saw}, 32'd0);
            end else begin
                chk($sformatf("v%0d_be", i), {28'd0, be}, {28'd0, tbl[i].be});
                chk($sformatf("v%0d_baddr", i), baddr, tbl[i].baddr);
                chk($sformatf("v%0d_we", i), {31'd0, bwe}, {31'd0, tbl[i].we});
                if (tbl[i].we) chk($sformatf("v%0d_bwdata", i), bwd, tbl[i].bwd);
            end
        end
        exp_rdata = 32'h00008000;

        // Ack while idle must not start or finish anything
        lsu_bus.bus_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("idle_ack_done", {31'd0, lsu_bus.done | lsu_bus.bus_req}, 32'd0);
        end
        lsu_bus.bus_ack = 1'b0;
        chk("idle_ack_rdata", lsu_bus.rdata, exp_rdata);

        // Dropping req_valid during BUS still completes the load
        lsu_bus.req_valid = 1'b1; lsu_bus.MemRW = 1'b0; lsu_bus.RSel = 3'b011;
        lsu_bus.addr = 32'h40; lsu_bus.bus_rdata = 32'h0BADF00D;
        tick();
        lsu_bus.req_valid = 1'b0;
        #1;
        chk("drop_req_bus", {31'd0, lsu_bus.bus_req}, 32'd1);
        chk("drop_req_stall", {31'd0, lsu_bus.stall}, 32'd0);
        lat = 0;
        for (int c = 0; c < 20; c++) begin
            lsu_bus.bus_ack = (c == 2);
            tick();
            if (lsu_bus.done) begin lat = c + 1; break; end
        end
        lsu_bus.bus_ack = 1'b0;
        chk("drop_req_done_cycle", lat, 32'd3);
        chk("drop_req_rdata", lsu_bus.rdata, 32'h0BADF00D);
        exp_rdata = 32'h0BADF00D;
        tick();

        for (int i = 0; i < 40; i++) begin
            logic        r_we;
            logic [1:0]  r_ws;
            logic [2:0]  r_rs;
            logic [31:0] r_a, r_wd, r_rd;
            int          r_dly;
            r_we  = 1'($urandom_range(0, 1));
            r_ws  = 2'($urandom_range(0, 3));
            r_rs  = 3'($urandom_range(0, 7));
            r_a   = $urandom;
            r_wd  = $urandom;
            r_rd  = $urandom;
            r_dly = $urandom_range(0, 3);
            model(r_we, r_ws, r_rs, r_a, r_wd, r_rd, m_err, m_be, m_bwd, m_ld);
            run_txn(r_we, r_ws, r_rs, r_a, r_wd, r_rd, r_dly, lat, mis, be, baddr, bwd, bwe, saw, sok);
            if (!m_err && !r_we) exp_rdata = m_ld;
            chk($sformatf("r%0d_latency", i), lat, m_err ? 32'd2 : 32'(3 + r_dly));
            chk($sformatf("r%0d_misaligned", i), {31'd0, mis}, {31'd0, m_err});
            chk($sformatf("r%0d_rdata", i), lsu_bus.rdata, exp_rdata);
            if (!m_err) begin
                chk($sformatf("r%0d_be", i), {28'd0, be}, {28'd0, m_be});
                chk($sformatf("r%0d_baddr", i), baddr, {r_a[31:2], 2'b00});
                if (r_we) chk($sformatf("r%0d_bwdata", i), bwd, m_bwd);
            end
        end

        // Reset on the third BUS cycle of a slow load abandons it
        lsu_bus.req_valid = 1'b1; lsu_bus.MemRW = 1'b0; lsu_bus.RSel = 3'b010;
        lsu_bus.addr = 32'h10; lsu_bus.bus_rdata = 32'h12345678; lsu_bus.bus_ack = 1'b0;
        tick(); tick(); tick();
        #1;
        chk("pre_rst_bus_req", {31'd0, lsu_bus.bus_req}, 32'd1);
        lsu_bus.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_outputs", {lsu_bus.done, lsu_bus.stall, lsu_bus.misaligned, lsu_bus.bus_req,
                                lsu_bus.bus_we, lsu_bus.bus_be}, 32'd0);
        chk("mid_rst_rdata", lsu_bus.rdata, 32'd0);
        chk("mid_rst_bus_addr", lsu_bus.bus_addr, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_no_done", {31'd0, lsu_bus.done}, 32'd0);
        run_txn(1'b0, 2'd0, 3'b010, 32'h12, 32'h0, 32'h7FFF0000, 0, lat, mis, be, baddr, bwd, bwe, saw, sok);
        chk("reissue_latency", lat, 32'd3);
        chk("reissue_rdata", lsu_bus.rdata, 32'h00007FFF);
        exp_rdata = 32'h00007FFF;

`ifdef LSU_TIMEOUT_EN
        run_txn(1'b0, 2'd0, 3'b011, 32'h80, 32'h0, 32'hFFFFFFFF, -1, lat, mis, be, baddr, bwd, bwe, saw, sok);
        chk("timeout_latency", lat, 32'(TO + 2));
        chk("timeout_misaligned", {31'd0, mis}, 32'd1);
        chk("timeout_saw_req", {31'd0, saw}, 32'd1);
        chk("timeout_rdata", lsu_bus.rdata, exp_rdata);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
